// File: rtl/dcache_sa.sv
// dcache_sa: set-associative, write-through, no-write-allocate data cache.
// Multi-word lines, 1-bit LRU per set, internal refill state machine.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   req_*                    CPU request (valid/ready), load or store
//   resp_valid, resp_rdata   one-cycle response pulse, load data (0 for stores)
//   inv_valid, inv_addr      single-cycle per-address invalidate (IDLE only)
//   mem_rd_*                 line read request channel (valid/ready)
//   mem_rdata_valid/rdata    refill beats, ascending word order
//   mem_wr_*                 write-through channel (valid/ready)
module dcache_sa #(
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    input  logic              inv_valid,
    input  logic [ADDR_W-1:0] inv_addr,
    output logic              mem_rd_valid,
    input  logic              mem_rd_ready,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rdata_valid,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_wr_strb
);
    localparam int OFF   = $clog2(LINE_WORDS) + 2;
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF - IDX;
    localparam int WW    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MISS_REQ = 3'd2;
    localparam logic [2:0] S_REFILL   = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              way_q, way_d;
    logic [WW-1:0]     cnt_q, cnt_d;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [SETS-1:0]   lru_q, lru_d;
    logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
    logic [31:0]       data_q [WAYS][SETS][LINE_WORDS];

    // Field extraction by shifting keeps LINE_WORDS == 1 legal (empty word field).
    logic [IDX-1:0]   req_idx, inv_idx;
    logic [WW-1:0]    req_word;
    logic [TAG_W-1:0] req_tag, inv_tag;
    assign req_idx  = IDX'(addr_q >> OFF);
    assign req_word = WW'((addr_q >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign req_tag  = TAG_W'(addr_q >> (OFF + IDX));
    assign inv_idx  = IDX'(inv_addr >> OFF);
    assign inv_tag  = TAG_W'(inv_addr >> (OFF + IDX));

    // Tag compare across all ways, and victim selection for a load miss:
    // lowest invalid way first, otherwise the set's LRU way.
    logic hit, hit_way, victim;
    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
        if (!valid_q[req_idx][0])
            victim = 1'b0;
        else if (WAYS == 2 && !valid_q[req_idx][WAYS-1])
            victim = 1'b1;
        else if (WAYS == 2)
            victim = lru_q[req_idx];
        else
            victim = 1'b0;
    end

    // Data-array write port: shared by store-hit merges and refill beats.
    logic          d_we, d_way, tag_we;
    logic [WW-1:0] d_word;
    logic [31:0]   d_wdata, old_word;
    assign old_word = data_q[hit_way][req_idx][req_word];

    // Next-state, array updates and outputs. Everything is forced quiet while
    // resetn is low so the outputs read 0 throughout reset.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        way_d      = way_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        lru_d      = lru_q;
        d_we       = 1'b0;
        d_way      = way_q;
        d_word     = req_word;
        d_wdata    = mem_rdata;
        tag_we     = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = '0;
        mem_rd_valid = 1'b0;
        mem_rd_addr  = '0;
        mem_wr_valid = 1'b0;
        mem_wr_addr  = '0;
        mem_wr_data  = '0;
        mem_wr_strb  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = !inv_valid;
                if (inv_valid) begin
                    for (int w = 0; w < WAYS; w++)
                        if (tag_q[w][inv_idx] == inv_tag)
                            valid_d[inv_idx][w] = 1'b0;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    lru_d[req_idx] = ~hit_way;
                    if (!wr_q) begin
                        resp_valid = 1'b1;
                        resp_rdata = old_word;
                        state_d    = S_IDLE;
                    end else begin
                        d_we  = 1'b1;
                        d_way = hit_way;
                        for (int b = 0; b < 4; b++)
                            d_wdata[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8]
                                                           : old_word[8*b +: 8];
                        state_d = S_WRITE;
                    end
                end else if (wr_q) begin
                    state_d = S_WRITE;
                end else begin
                    way_d   = victim;
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                mem_rd_valid = 1'b1;
                mem_rd_addr  = addr_q & ~ADDR_W'(LINE_WORDS * 4 - 1);
                if (mem_rd_ready) begin
                    valid_d[req_idx][way_q] = 1'b0;
                    cnt_d   = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_rdata_valid) begin
                    d_we   = 1'b1;
                    d_word = cnt_q;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == WW'(LINE_WORDS - 1)) begin
                        valid_d[req_idx][way_q] = 1'b1;
                        tag_we  = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                resp_valid     = 1'b1;
                resp_rdata     = data_q[way_q][req_idx][req_word];
                lru_d[req_idx] = ~way_q;
                state_d        = S_IDLE;
            end
            S_WRITE: begin
                mem_wr_valid = 1'b1;
                mem_wr_addr  = addr_q;
                mem_wr_data  = wdata_q;
                mem_wr_strb  = wstrb_q;
                if (mem_wr_ready) begin
                    resp_valid = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!resetn) begin
            d_we         = 1'b0;
            tag_we       = 1'b0;
            req_ready    = 1'b0;
            resp_valid   = 1'b0;
            resp_rdata   = '0;
            mem_rd_valid = 1'b0;
            mem_rd_addr  = '0;
            mem_wr_valid = 1'b0;
            mem_wr_addr  = '0;
            mem_wr_data  = '0;
            mem_wr_strb  = '0;
        end
    end

    // Control state and valid/LRU bits; reset abandons any refill in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            way_q   <= 1'b0;
            cnt_q   <= '0;
            lru_q   <= '0;
            for (int s = 0; s < SETS; s++)
                valid_q[s] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            way_q   <= way_d;
            cnt_q   <= cnt_d;
            lru_q   <= lru_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data storage need no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (d_we)
            data_q[d_way][req_idx][d_word] <= d_wdata;
        if (tag_we)
            tag_q[way_q][req_idx] <= req_tag;
    end
endmodule
